// File: rtl/bpred_pkg.sv
// Shared types and widths for the fetch-stage branch predictor.
// Counter encoding and the saturating counter step live here.
package bpred_pkg;

    localparam int PHT_IDX_W = 8;
    localparam int PHT_ENTRIES_DEF = 256;
    localparam int BTB_ENTRIES_DEF = 32;
    localparam int BTB_IDX_W = 5;
    localparam int BTB_TAG_W = 32 - 2 - BTB_IDX_W;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    localparam ctr_t PHT_RESET = WNT;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bpred_pht.sv
// Pattern history table of 2-bit saturating counters.
// Combinational read; synchronous write; reads see pre-write value.
module bpred_pht
    import bpred_pkg::*;
#(
    parameter int ENTRIES = PHT_ENTRIES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PHT_IDX_W-1:0] rd_idx,
    output ctr_t                 rd_ctr,
    input  logic                 wr_en,
    input  logic                 wr_taken,
    input  logic [PHT_IDX_W-1:0] wr_idx
);

    ctr_t ctr_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= PHT_RESET;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
        end
    end

    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/fetch_bpred_stage.sv
// Fetch stage: PC register, PHT + direct-mapped BTB prediction.
// Define GSHARE_EN to hash the PHT index with a global history register.
module fetch_bpred_stage
    import bpred_pkg::*;
#(
    parameter int          PHT_ENTRIES = PHT_ENTRIES_DEF,
    parameter int          BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic                 ex_update_en,
    input  logic                 ex_actual_taken,
    input  logic [31:0]          ex_pc,
    input  logic [31:0]          ex_actual_target,
    input  logic [PHT_IDX_W-1:0] ex_pht_idx,
    output logic [31:0]          im_addr,
    output logic [31:0]          F_PC,
    output logic                 F_pred_taken,
    output logic [PHT_IDX_W-1:0] F_pht_idx,
    output logic                 F_btb_hit,
    output logic [31:0]          F_btb_target
);

    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int BTB_TW = 30 - BTB_IW;

    logic [31:0]            pc_q;
    logic [31:0]            pc_d;
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [BTB_TW-1:0]      btb_tag [BTB_ENTRIES];
    logic [31:0]            btb_tgt [BTB_ENTRIES];
    logic [BTB_IW-1:0]      rd_bi;
    logic [BTB_IW-1:0]      wr_bi;
    logic                   btb_wr;
    logic [PHT_IDX_W-1:0]   pht_idx;
    ctr_t                   rd_ctr;
    logic                   unused_bits;

    assign unused_bits = ^ex_pc[1:0];

    assign rd_bi  = pc_q[2 +: BTB_IW];
    assign wr_bi  = ex_pc[2 +: BTB_IW];
    assign btb_wr = ex_update_en && ex_actual_taken;

`ifdef GSHARE_EN
    logic [PHT_IDX_W-1:0] ghr;

    // History advances in resolve order only; redirects never roll it back.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr <= '0;
        end else if (ex_update_en) begin
            ghr <= {ghr[PHT_IDX_W-2:0], ex_actual_taken};
        end
    end

    assign pht_idx = pc_q[2 +: PHT_IDX_W] ^ ghr;
`else
    assign pht_idx = pc_q[2 +: PHT_IDX_W];
`endif

    bpred_pht #(
        .ENTRIES (PHT_ENTRIES)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pht_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (ex_update_en),
        .wr_taken (ex_actual_taken),
        .wr_idx   (ex_pht_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            btb_valid <= '0;
        end else if (btb_wr) begin
            btb_valid[wr_bi] <= 1'b1;
        end
    end

    // Payload needs no reset: it is qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (rst && btb_wr) begin
            btb_tag[wr_bi] <= ex_pc[31 -: BTB_TW];
            btb_tgt[wr_bi] <= ex_actual_target;
        end
    end

    assign F_btb_hit    = btb_valid[rd_bi] &&
                          (btb_tag[rd_bi] == pc_q[31 -: BTB_TW]);
    assign F_btb_target = F_btb_hit ? btb_tgt[rd_bi] : 32'h0;
    assign F_pred_taken = F_btb_hit && (rd_ctr inside {WT, ST});
    assign F_pht_idx    = pht_idx;
    assign F_PC         = pc_q;
    assign im_addr      = pc_q;

    always_comb begin
        pc_d = pc_q + 32'd4;
        priority case (1'b1)
            redirect_valid: pc_d = redirect_pc;
            stall:          pc_d = pc_q;
            F_pred_taken:   pc_d = F_btb_target;
            default:        pc_d = pc_q + 32'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
